// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and constants for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

  // Default operand / result width.
  localparam int MD_WIDTH = 32;

  // Quotient returned for a zero divisor.
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  // Decoded mul/div opcode carried in the ID/EX register.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative signed multiply (low word) / divide / remainder unit for the EX
// stage. One shift-add or restoring-divide step per cycle over WIDTH cycles,
// sign correction on the last step, then a one-cycle DONE with the result.
//
// Handshake: an instruction is offered when req_i is high with op_i != NONE.
// It is taken in IDLE on the same edge (unless flush_i is high); stall_o goes
// high combinationally in that offering cycle and stays high through BUSY so
// the pipeline holds the instruction. done_o marks the single cycle in which
// result_o must be captured; stall_o is low then so the pipeline advances.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] RSdata_i,
  input  logic [WIDTH-1:0] RTdata_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int ITER = WIDTH;
  localparam int CW   = $clog2(WIDTH) + 1;

  // State (state_q is the observable FSM state for checkers).
  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;       // |A|; shifted left during divide
  logic [WIDTH-1:0]   b_q, b_d;       // |B|; shifted right during multiply
  logic [2*WIDTH-1:0] acc_q, acc_d;   // mul: {hi,lo} product; div: {rem,quot}
  md_op_e             op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Datapath intermediates.
  logic               accept;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] div_acc;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   fixed;
  logic               last_step;

  assign accept = (state_q == ST_IDLE) && req_i && (md_op_e'(op_i) != OP_NONE) && !flush_i;
  assign a_abs  = RSdata_i[WIDTH-1] ? -RSdata_i : RSdata_i;
  assign b_abs  = RTdata_i[WIDTH-1] ? -RTdata_i : RTdata_i;

  // One iteration of shift-add multiply and restoring divide, plus sign fix.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, b_q};
    q_bit     = ~diff[WIDTH];  // no borrow: divisor fits
    rem_nxt   = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_acc   = {rem_nxt, acc_q[WIDTH-2:0], q_bit};
    step_acc  = (op_q == OP_MUL) ? mul_acc : div_acc;
    last_step = (cnt_q == CW'(ITER - 1));
    case (op_q)
      OP_MUL:  fixed = (sign_a_q ^ sign_b_q) ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      OP_DIV:  fixed = (b_q == '0) ? WIDTH'(DIV_BY_ZERO_Q) :
                       ((sign_a_q ^ sign_b_q) ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0]);
      OP_REM:  fixed = sign_a_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
      default: fixed = step_acc[WIDTH-1:0];
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          a_d      = a_abs;
          b_d      = b_abs;
          acc_d    = '0;
          op_d     = md_op_e'(op_i);
          sign_a_d = RSdata_i[WIDTH-1];
          sign_b_d = RTdata_i[WIDTH-1];
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CW'(1);
          if (op_q == OP_MUL) b_d = b_q >> 1;
          else                a_d = a_q << 1;
          if (last_step) begin
            result_d = fixed;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register bank with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= OP_NONE;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = ((state_q == ST_IDLE) && req_i && (md_op_e'(op_i) != OP_NONE)) ||
                    (state_q == ST_BUSY);
  assign done_o   = (state_q == ST_DONE) && !flush_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of reference results, latency
// and stall-length checks, flush and asynchronous-reset aborts.
module tb_ex_muldiv;

  localparam logic [1:0] MUL = 2'b01;
  localparam logic [1:0] DIV = 2'b10;
  localparam logic [1:0] REM = 2'b11;

  // Clock / reset block.
  logic        clk_i = 1'b0;
  logic        start_i;
  logic        req_i;
  logic [1:0]  op_i;
  logic [31:0] RSdata_i;
  logic [31:0] RTdata_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  always #5 clk_i = ~clk_i;

  ex_muldiv dut (
    .clk_i    (clk_i),
    .start_i  (start_i),
    .req_i    (req_i),
    .op_i     (op_i),
    .RSdata_i (RSdata_i),
    .RTdata_i (RTdata_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  // Scoreboard.
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] last_result;
  int          checks;
  int          failures;

  // Observations from the driver.
  logic [31:0] obs_result;
  int          obs_lat;
  int          obs_stalls;
  bit          obs_done;

  // Reference model with signed semantics and the special cases.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      MUL: begin
        p = 64'(sa) * 64'(sb);
        return p[31:0];
      end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return 32'd0;
    endcase
  endfunction

  // Driver: offer one op in cycle 0, then watch up to 40 cycles for done_o.
  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    req_i    = 1'b1;
    op_i     = op;
    RSdata_i = a;
    RTdata_i = b;
    exp_q.push_back(ref_model(op, a, b));
    obs_stalls = 0;
    obs_done   = 1'b0;
    obs_lat    = -1;
    obs_result = 32'd0;
    #1;
    if (stall_o) obs_stalls++;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      op_i  = 2'b00;
      #1;
      if (done_o) begin
        obs_done   = 1'b1;
        obs_lat    = cyc;
        obs_result = result_o;
        if (stall_o) obs_stalls++;
        break;
      end
      if (stall_o) obs_stalls++;
    end
  endtask

  task automatic test_reset();
    start_i  = 1'b0;
    req_i    = 1'b0;
    op_i     = 2'b00;
    RSdata_i = 32'd0;
    RTdata_i = 32'd0;
    flush_i  = 1'b0;
    #1;
    checks++;
    if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=%h", result_o, 32'd0); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    req_i = 1'b1;
    op_i  = MUL;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin failures++; $display("FAIL reset_accept_stall got=%b exp=1", stall_o); end
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL reset_hold_done got=%b exp=0", done_o); end
    req_i = 1'b0;
    op_i  = 2'b00;
    @(negedge clk_i);
    start_i     = 1'b1;
    last_result = 32'd0;
  endtask

  task automatic test_mul();
    logic [31:0] ta[3] = '{32'hFFFF_FFFD, 32'h0001_0003, 32'h8000_0000};
    logic [31:0] tb[3] = '{32'd7,         32'hFFFF_0002, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      issue_op(MUL, ta[i], tb[i]);
      exp_v = exp_q.pop_front();
      checks++;
      if (!obs_done) begin failures++; $display("FAIL mul_timeout case=%0d got=no_done exp=done", i); end
      checks++;
      if (obs_lat != 33) begin failures++; $display("FAIL mul_latency case=%0d got=%0d exp=33", i, obs_lat); end
      checks++;
      if (obs_stalls != 33) begin failures++; $display("FAIL mul_stalls case=%0d got=%0d exp=33", i, obs_stalls); end
      checks++;
      if (obs_result !== exp_v) begin failures++; $display("FAIL mul_result case=%0d got=%h exp=%h", i, obs_result, exp_v); end
      last_result = exp_v;
    end
  endtask

  task automatic test_div_rem();
    logic [1:0]  to[4] = '{DIV, REM, DIV, REM};
    logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] tb[4] = '{32'd2, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    for (int i = 0; i < 4; i++) begin
      issue_op(to[i], ta[i], tb[i]);
      exp_v = exp_q.pop_front();
      checks++;
      if (!obs_done) begin failures++; $display("FAIL divrem_timeout case=%0d got=no_done exp=done", i); end
      checks++;
      if (obs_lat != 33) begin failures++; $display("FAIL divrem_latency case=%0d got=%0d exp=33", i, obs_lat); end
      checks++;
      if (obs_result !== exp_v) begin failures++; $display("FAIL divrem_result case=%0d got=%h exp=%h", i, obs_result, exp_v); end
      last_result = exp_v;
    end
    // The last case (100 rem -7 = 2) leaves a nonzero held result.
  endtask

  task automatic test_div_zero();
    logic [1:0]  to[4] = '{DIV, REM, DIV, REM};
    logic [31:0] ta[4] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    for (int i = 0; i < 4; i++) begin
      issue_op(to[i], ta[i], 32'd0);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_lat != 33) begin failures++; $display("FAIL divzero_latency case=%0d got=%0d exp=33", i, obs_lat); end
      checks++;
      if (obs_stalls != 33) begin failures++; $display("FAIL divzero_stalls case=%0d got=%0d exp=33", i, obs_stalls); end
      checks++;
      if (obs_result !== exp_v) begin failures++; $display("FAIL divzero_result case=%0d got=%h exp=%h", i, obs_result, exp_v); end
      last_result = exp_v;
    end
  endtask

  task automatic test_overflow();
    logic [1:0] to[2] = '{DIV, REM};
    for (int i = 0; i < 2; i++) begin
      issue_op(to[i], 32'h8000_0000, 32'hFFFF_FFFF);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_lat != 33) begin failures++; $display("FAIL overflow_latency case=%0d got=%0d exp=33", i, obs_lat); end
      checks++;
      if (obs_result !== exp_v) begin failures++; $display("FAIL overflow_result case=%0d got=%h exp=%h", i, obs_result, exp_v); end
      last_result = exp_v;
    end
  endtask

  task automatic test_flush();
    int done_seen;
    @(negedge clk_i);
    req_i    = 1'b1;
    op_i     = MUL;
    RSdata_i = 32'd1234;
    RTdata_i = 32'd99;
    @(negedge clk_i);            // cycle 1
    req_i = 1'b0;
    op_i  = 2'b00;
    repeat (9) @(negedge clk_i); // cycle 10
    flush_i = 1'b1;
    @(negedge clk_i);            // cycle 11
    flush_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", done_o); end
    checks++;
    if (result_o !== last_result) begin failures++; $display("FAIL flush_result_hold got=%h exp=%h", result_o, last_result); end
    done_seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk_i);
      #1;
      if (done_o) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", done_seen); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    req_i    = 1'b1;
    op_i     = DIV;
    RSdata_i = 32'd1000;
    RTdata_i = 32'd3;
    @(negedge clk_i);             // cycle 1
    req_i = 1'b0;
    op_i  = 2'b00;
    repeat (19) @(negedge clk_i); // cycle 20
    start_i = 1'b0;
    #1;
    checks++;
    if (result_o !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=%h", result_o, 32'd0); end
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", stall_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done_o); end
    @(negedge clk_i);
    start_i     = 1'b1;
    last_result = 32'd0;
    issue_op(MUL, 32'd6, 32'd7);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_lat != 33) begin failures++; $display("FAIL rstmid_mul_latency got=%0d exp=33", obs_lat); end
    checks++;
    if (obs_result !== exp_v) begin failures++; $display("FAIL rstmid_mul_result got=%h exp=%h", obs_result, exp_v); end
    last_result = exp_v;
  endtask

  // Operations issued in cycle 34 of the previous one, random operands.
  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(1, 3));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom();
      issue_op(op, a, b);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_lat != 33) begin failures++; $display("FAIL b2b_latency case=%0d got=%0d exp=33", i, obs_lat); end
      checks++;
      if (obs_result !== exp_v) begin
        failures++;
        $display("FAIL b2b_result case=%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, obs_result, exp_v);
      end
      last_result = exp_v;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_div_rem();
    test_flush();
    test_reset_mid();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs (RS/RT data plus a decoded mul/div opcode). It runs a 32-step shift-add multiply or restoring divide. While it runs, it raises a stall that freezes PC, IF/ID and ID/EX. It then presents a 32-bit result for one cycle, and the EX/MEM register captures that result as the ALU result.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; `ITER` = `WIDTH` steps per operation.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `start_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  ID/EX holds a mul/div instruction this cycle.
- `op_i`  in  2  00 none, 01 MUL (signed, low word), 10 DIV (signed quotient), 11 REM (signed remainder).
- `RSdata_i`  in  32  operand A (multiplicand / dividend).
- `RTdata_i`  in  32  operand B (multiplier / divisor).
- `flush_i`  in  1  synchronous abort (branch taken / squash).
- `stall_o`  out  1  hold PC, IF/ID, ID/EX; insert bubble into EX/MEM.
- `done_o`  out  1  one-cycle pulse; `result_o` valid.
- `result_o`  out  32  product low word / quotient / remainder.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If `req_i` is high and `op_i` is not 00: latch |A|, |B|, op, and the sign of each operand; clear the accumulator; set the counter to 0; go to BUSY.
  - `req_i` with `op_i`=00 is ignored.
- **BUSY**
  - Performs one iteration per cycle; the counter increments.
  - MUL is shift-add into a 64-bit accumulator. DIV and REM are restoring division: shift the remainder left, trial-subtract |B|, and the quotient bit is 1 when no borrow occurs.
  - After iteration `ITER`-1, apply sign correction, register it into `result_o`, and go to DONE.
- **DONE**
  - `done_o`=1 and `stall_o`=0, so the pipeline advances at this edge.
  - The next state is always IDLE. `req_i` is not re-sampled in DONE.
- **Sign rules**
  - MUL result is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Only the low 32 bits are kept.
- **Divide by zero:** quotient = 0xFFFF_FFFF, remainder = A. The unit still takes the full `ITER` cycles.
- **Overflow:** 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0.
- **`stall_o`** = (IDLE & `req_i` & `op_i`≠00) | BUSY. The IDLE term is combinational so the accepting cycle is also stalled.
- **`flush_i`** in BUSY or DONE returns the unit to IDLE next edge with no `done_o` pulse. Flush has priority over accept.
- **`result_o`** holds its value until the next DONE.

## Timing
- Accept in cycle 0. BUSY occupies cycles 1..32. DONE is cycle 33.
- `stall_o` is high in cycles 0..32, i.e. 33 stalled cycles.
- EX/MEM captures `result_o` at the end of cycle 33.
- Back-to-back operations: a new `req_i` is seen in cycle 34 in IDLE.
- **Reset** (`start_i` low, any time including mid-operation), effective immediately:
  - state IDLE, counter 0, accumulators 0;
  - `result_o`=0, `done_o`=0;
  - `stall_o`=0 unless the combinational accept term holds.

## Structure
- Shared package holds:
  - op encodings (NONE, MUL, DIV, REM);
  - state encodings (IDLE, BUSY, DONE);
  - `WIDTH` default;
  - divide-by-zero quotient constant 0xFFFF_FFFF.
- No sub-module: the datapath (operand magnitude, 64-bit accumulator, 6-bit counter, sign fix) and the FSM fit in one flat module.

## Test plan
- **Signed MUL:** MUL, A=0xFFFF_FFFD (-3), B=7 -> `stall_o` high for 33 cycles, `done_o` in cycle 33, `result_o`=0xFFFF_FFEB (-21).
- **Signed DIV/REM:** DIV A=-7, B=2 -> 0xFFFF_FFFD (-3). REM with the same operands -> 0xFFFF_FFFF (-1).
- **Divide by zero:** DIV A=5, B=0 -> 0xFFFF_FFFF. REM A=5, B=0 -> 5. Latency unchanged at 33 cycles.
- **Overflow:** DIV A=0x8000_0000, B=0xFFFF_FFFF -> 0x8000_0000. REM with the same operands -> 0.
- **Flush mid-operation:** `flush_i` pulsed in BUSY cycle 10 -> IDLE next cycle, `stall_o`=0, no `done_o`, `result_o` keeps its previous value.
- **Reset mid-operation:** `start_i` low in BUSY cycle 20 -> IDLE immediately, `result_o`=0. A following MUL 6×7 -> 42 after the full 33 cycles.
